// File: rtl/parallel_to_serial_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
// The FSM state type and bit-order encodings are used by the RTL and the bench.
package parallel_to_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fsm_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // One FIFO entry carries the word plus its bit-order flag in the top bit.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_buf_fifo.sv
// Synchronous word FIFO with registered occupancy. full/empty come from the
// registered level only, so a same-edge pop never frees a slot for a push.
module sync_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/parallel_to_serial_buf.sv
// Parallel-to-serial converter: word FIFO in front of a shifter that emits one
// bit per clock with per-word bit order, sof/eof framing and sticky overflow.
module parallel_to_serial_buf
  import parallel_to_serial_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_en,
  output logic                  din_rdy,
  input  logic                  lsb_first,
  input  logic                  ovf_clr,
  output logic                  dout,
  output logic                  rdy,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic                  overflow,
  output logic [LVL_W-1:0]      level,
  output fsm_t                  state_dbg
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH);
  localparam int CNT_W   = $clog2(DATA_WIDTH);

  // Valid/ready contract on the input side: a word transfers on a rising edge
  // where din_en and din_rdy are both 1; din_en while din_rdy is 0 is a drop.
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LVL_W-1:0]      fifo_level;
  logic                  fifo_push;
  logic                  fifo_pop;

  fsm_t                  state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  dout_q;
  logic                  rdy_q;
  logic                  sof_q;
  logic                  eof_q;
  logic                  ovf_q, ovf_d;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] load_word_d;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({lsb_first, din}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign fifo_push = din_en & ~fifo_full;
  assign last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == SHIFT) & last_bit));

  // The shifter always emits from its MSB, so LSB-first words are reversed on load.
  always_comb begin
    load_word_d = fifo_rdata[DATA_WIDTH-1:0];
    if (fifo_rdata[DATA_WIDTH] == LSB_FIRST) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        load_word_d[i] = fifo_rdata[DATA_WIDTH-1-i];
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q & ~ovf_clr;
    if (din_en & fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
      rdy_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            state_q   <= SHIFT;
            shreg_q   <= load_word_d;
            bit_cnt_q <= '0;
            dout_q    <= load_word_d[DATA_WIDTH-1];
            rdy_q     <= 1'b1;
            sof_q     <= 1'b1;
            eof_q     <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            // Reloading here keeps back-to-back words free of idle gaps.
            if (fifo_pop) begin
              shreg_q   <= load_word_d;
              bit_cnt_q <= '0;
              dout_q    <= load_word_d[DATA_WIDTH-1];
              rdy_q     <= 1'b1;
              sof_q     <= 1'b1;
              eof_q     <= 1'b0;
            end else begin
              state_q   <= IDLE;
              shreg_q   <= '0;
              bit_cnt_q <= '0;
              dout_q    <= 1'b0;
              rdy_q     <= 1'b0;
              sof_q     <= 1'b0;
              eof_q     <= 1'b0;
            end
          end else begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            dout_q    <= shreg_q[DATA_WIDTH-2];
            sof_q     <= 1'b0;
            eof_q     <= (bit_cnt_q == CNT_W'(DATA_WIDTH - 2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din_rdy   = ~fifo_full;
  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign dout_sof  = sof_q;
  assign dout_eof  = eof_q;
  assign overflow  = ovf_q;
  assign level     = fifo_level;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_parallel_to_serial_buf.sv
// Bench for parallel_to_serial_buf: queue-level model checked every cycle plus
// directed scenarios with hand-computed bit streams.
module tb_parallel_to_serial_buf;
  import parallel_to_serial_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b1;
  logic [DW-1:0] din       = '0;
  logic          din_en    = 1'b0;
  logic          lsb_first = 1'b0;
  logic          ovf_clr   = 1'b0;
  logic          din_rdy;
  logic          dout;
  logic          rdy;
  logic          dout_sof;
  logic          dout_eof;
  logic          overflow;
  logic [LVL_W-1:0] level;
  fsm_t          state_dbg;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int first_cyc = 0;
  int last_cyc  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  parallel_to_serial_buf #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_en    (din_en),
    .din_rdy   (din_rdy),
    .lsb_first (lsb_first),
    .ovf_clr   (ovf_clr),
    .dout      (dout),
    .rdy       (rdy),
    .dout_sof  (dout_sof),
    .dout_eof  (dout_eof),
    .overflow  (overflow),
    .level     (level),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds queued words {order, data}; cur holds the bits of the word on
  // the link, cur[0] being the bit currently shown.
  logic [DW:0] exp_q[$];
  bit          cur[$];
  bit          m_ovf = 1'b0;
  logic [DW:0] m_word;
  bit          m_full;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      cur.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      if (cur.size() <= 1) begin
        cur.delete();
        if (exp_q.size() > 0) begin
          m_word = exp_q.pop_front();
          if (m_word[DW]) begin
            for (int i = 0; i < DW; i++) cur.push_back(m_word[i]);
          end else begin
            for (int i = DW - 1; i >= 0; i--) cur.push_back(m_word[i]);
          end
        end
      end else begin
        void'(cur.pop_front());
      end
      if (din_en && m_full) m_ovf = 1'b1;
      else if (ovf_clr)     m_ovf = 1'b0;
      if (din_en && !m_full) exp_q.push_back({lsb_first, din});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit e_rdy;
    e_rdy = (cur.size() > 0);
    check("rdy",      64'(rdy),      64'(e_rdy));
    check("dout",     64'(dout),     64'(e_rdy ? cur[0] : 1'b0));
    check("dout_sof", 64'(dout_sof), 64'(e_rdy && cur.size() == DW));
    check("dout_eof", 64'(dout_eof), 64'(cur.size() == 1));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("level",    64'(level),    64'(exp_q.size()));
    check("din_rdy",  64'(din_rdy),  64'(exp_q.size() < DEPTH));
  end

  // ---------------- output recorder ----------------
  bit rec_b[$];
  bit rec_s[$];
  bit rec_e[$];

  always @(negedge clk) begin
    if (resetn && rdy) begin
      if (rec_b.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      rec_b.push_back(dout);
      rec_s.push_back(dout_sof);
      rec_e.push_back(dout_eof);
    end
  end

  function automatic logic [63:0] pack(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v = (v << 1) | 64'(q[i]);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_rec();
    rec_b.delete();
    rec_s.delete();
    rec_e.delete();
  endtask

  task automatic push_word(input logic [DW-1:0] w, input logic lsb);
    @(negedge clk);
    din       = w;
    lsb_first = lsb;
    din_en    = 1'b1;
    acc_cyc   = cyc + 1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    din       = '0;
    lsb_first = 1'b0;
    din_en    = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    #1;
    while ((rdy || level != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 64'(rdy || level != 0), 64'(0));
  endtask

  task automatic check_stream(input string name, input int n,
                              input logic [63:0] bits, input logic [63:0] sof,
                              input logic [63:0] eof);
    check({name, "_count"}, 64'(rec_b.size()), 64'(n));
    check({name, "_bits"},  pack(rec_b), bits);
    check({name, "_sof"},   pack(rec_s), sof);
    check({name, "_eof"},   pack(rec_e), eof);
    check({name, "_contig"}, 64'(last_cyc - first_cyc), 64'(n - 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy",      64'(rdy),       64'(0));
    check("rst_dout",     64'(dout),      64'(0));
    check("rst_sof_eof",  64'({dout_sof, dout_eof}), 64'(0));
    check("rst_overflow", 64'(overflow),  64'(0));
    check("rst_level",    64'(level),     64'(0));
    check("rst_din_rdy",  64'(din_rdy),   64'(1));
    check("rst_state",    64'(state_dbg), 64'(IDLE));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, MSB first
    clear_rec();
    push_word(4'b1010, MSB_FIRST);
    idle_in();
    wait_drain("t1", 50);
    check_stream("t1", 4, 64'b1010, 64'b1000, 64'b0001);
    check("t1_latency", 64'(first_cyc - acc_cyc), 64'(1));

    // Single word, LSB first
    clear_rec();
    push_word(4'b0011, LSB_FIRST);
    idle_in();
    wait_drain("t2", 50);
    check_stream("t2", 4, 64'b1100, 64'b1000, 64'b0001);

    // Back-to-back
    clear_rec();
    push_word(4'b1111, MSB_FIRST);
    push_word(4'b0000, MSB_FIRST);
    push_word(4'b0100, MSB_FIRST);
    idle_in();
    wait_drain("t3", 50);
    check_stream("t3", 12, 64'b1111_0000_0100, 64'b1000_1000_1000, 64'b0001_0001_0001);

    // Overflow; the drop and ovf_clr share an edge, so the set must win
    clear_rec();
    for (int w = 1; w <= 5; w++) push_word(DW'(w), MSB_FIRST);
    @(negedge clk);
    check("t4_level_full", 64'(level),   64'(4));
    check("t4_din_rdy",    64'(din_rdy), 64'(0));
    din     = 4'd6;
    din_en  = 1'b1;
    ovf_clr = 1'b1;
    idle_in();
    check("t4_ovf_set", 64'(overflow), 64'(1));
    wait_drain("t4", 80);
    check_stream("t4", 20, 64'h12345, 64'h88888, 64'h11111);
    check("t4_ovf_sticky", 64'(overflow), 64'(1));
    @(negedge clk);
    ovf_clr = 1'b1;
    idle_in();
    check("t4_ovf_clr", 64'(overflow), 64'(0));

    // Reset mid-word
    clear_rec();
    push_word(4'b1100, MSB_FIRST);
    idle_in();
    n = 0;
    while (rec_b.size() < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_two_bits", 64'(rec_b.size()), 64'(2));
    resetn = 1'b0;
    #1;
    check("t5_rst_rdy",     64'(rdy),     64'(0));
    check("t5_rst_dout",    64'(dout),    64'(0));
    check("t5_rst_level",   64'(level),   64'(0));
    check("t5_rst_din_rdy", 64'(din_rdy), 64'(1));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_rec();
    push_word(4'b0001, MSB_FIRST);
    idle_in();
    wait_drain("t5", 50);
    check_stream("t5", 4, 64'b0001, 64'b1000, 64'b0001);

    // Mixed order back-to-back
    clear_rec();
    push_word(4'b1000, MSB_FIRST);
    push_word(4'b1000, LSB_FIRST);
    idle_in();
    wait_drain("t6", 50);
    check_stream("t6", 8, 64'b1000_0001, 64'b1000_1000, 64'b0001_0001);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parallel_to_serial_buf.md
Name: parallel_to_serial_buf

Overview:
Next-generation parallel-to-serial converter. Parallel words enter an internal word FIFO with a valid/ready handshake and are shifted out one bit per clock. The block adds per-word selectable bit order, start/end-of-word framing and overflow reporting. It sits between a word-rate producer and a bit-serial link, and emits back-to-back words with no idle gap.

Parameters:
- DATA_WIDTH, 4, bits per parallel word; must be >= 2.
- FIFO_DEPTH, 4, words of buffering in front of the shifter; power of 2, >= 2.
- LVL_W, $clog2(FIFO_DEPTH+1), localparam: width of the level output.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  parallel word.
- din_en  in  1  word valid.
- din_rdy  out  1  FIFO can accept a word; equals not-full.
- lsb_first  in  1  bit order; sampled with each accepted word.
- ovf_clr  in  1  clears the sticky overflow flag.
- dout  out  1  serial bit.
- rdy  out  1  dout carries a valid bit.
- dout_sof  out  1  first bit of a word.
- dout_eof  out  1  last bit of a word.
- overflow  out  1  sticky: a word was offered while din_rdy was 0.
- level  out  LVL_W  FIFO occupancy in words (excludes the word in the shifter).

Behaviour:
- Reset (resetn low, asynchronous): all outputs are registered to 0, except din_rdy=1. FIFO pointers, level, bit counter and shifter are cleared. State is IDLE.
- Reset mid-word: the word in the shifter is discarded and the FIFO is flushed immediately. No partial word is resumed after release.
- Accept rule: a word is accepted on an edge where din_en=1 and din_rdy=1. din and lsb_first are stored together as one FIFO entry (DATA_WIDTH+1 bits).
- Full FIFO: din_rdy is derived only from the registered level, so a pop on the same edge does not free a slot for a push. A push with din_en=1 while full is dropped and sets overflow on that edge.
- overflow: stays 1 until an ovf_clr edge. If a new drop and ovf_clr occur on the same edge, the set wins.
- State machine:
  - IDLE: on an edge where the FIFO is non-empty, pop, load the shifter, set bit_cnt=0, go to SHIFT.
  - SHIFT: one bit per clock. On the edge with bit_cnt=DATA_WIDTH-1, pop and reload if the FIFO is non-empty (stay in SHIFT, bit_cnt=0); otherwise go to IDLE.
- Latency: a word accepted on edge k into an empty FIFO in IDLE is loaded on edge k+1. Its first bit is valid in the cycle following edge k+1, i.e. 2 cycles after acceptance.
- Bit order: MSB first when the stored lsb_first=0, LSB first when 1.
- Framing:
  - dout_sof=1 together with rdy for the first bit of each word.
  - dout_eof=1 for the last bit.
  - Back-to-back words: eof of word n is immediately followed by sof of word n+1, rdy stays 1 throughout.
- Idle output: when rdy=0, dout, dout_sof and dout_eof are 0.
- level: push only +1, pop only -1, push and pop together unchanged. It never exceeds FIFO_DEPTH and never wraps. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package parallel_to_serial_pkg holds:
  - state enum fsm_t {IDLE, SHIFT};
  - bit-order constants MSB_FIRST=0, LSB_FIRST=1.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop, full/empty and level.
- The top level contains the shifter, bit counter, FSM and flags.

Test Plan (DATA_WIDTH=4, FIFO_DEPTH=4):
- Single word, MSB first: push 4'b1010 with lsb_first=0 while idle -> rdy=1 for exactly 4 cycles starting 2 cycles after accept; dout=1,0,1,0; sof on bit 0, eof on bit 3; then rdy=0.
- Single word, LSB first: push 4'b0011 with lsb_first=1 -> dout=1,1,0,0.
- Back-to-back: push 1111, 0000, 0100 (MSB first) on consecutive edges -> 12 contiguous rdy=1 cycles; dout=1111 0000 0100; eof/sof adjacent at both word boundaries.
- Overflow: push 6 words on 6 consecutive edges from empty -> level reaches 4 after edge 5; din_rdy=0 on edge 6; word 6 dropped; overflow=1. 20 bits are output (words 1-5). Pulsing ovf_clr then returns overflow=0.
- Reset mid-word: push 4'b1100, assert resetn low after 2 output bits -> rdy, dout, level go to 0 immediately; din_rdy=1. After release, push 4'b0001 -> dout=0,0,0,1 with clean framing.
- Mixed order back-to-back: push 4'b1000 with lsb_first=0, then 4'b1000 with lsb_first=1 -> dout=1,0,0,0,0,0,0,1.
